// File: rtl/retire_trace_pkg.sv
// Shared types and defaults for the retirement trace buffer.
// The record layout is fixed here so producer, storage and consumer agree on it.
package retire_trace_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [63:0]             order;
        logic [XLEN_DEFAULT-1:0] pc_rdata;
        logic [XLEN_DEFAULT-1:0] pc_wdata;
        logic [31:0]             insn;
        logic [4:0]              rd_addr;
        logic [XLEN_DEFAULT-1:0] rd_wdata;
        logic                    drained;
    } trace_rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retirement-side and trace-side signals of the trace buffer.
// slave is the buffer's view, master the view of whoever drives retirements and consumes records.
interface retire_trace_buffer_if #(
    parameter int XLEN = retire_trace_pkg::XLEN_DEFAULT
);
    import retire_trace_pkg::*;

    logic             wb_valid_i;
    logic [XLEN-1:0]  wb_pc_i;
    logic [31:0]      wb_insn_i;
    logic             wb_we_i;
    logic [4:0]       wb_dst_i;
    logic [XLEN-1:0]  wb_r_i;
    logic             drain_i;
    logic             trace_valid_o;
    logic             trace_ready_i;
    trace_rec_t       trace_o;
    logic             overflow_o;
    logic [15:0]      drop_cnt_o;

    modport slave (
        input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i,
        input  drain_i, trace_ready_i,
        output trace_valid_o, trace_o, overflow_o, drop_cnt_o
    );

    modport master (
        output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i,
        output drain_i, trace_ready_i,
        input  trace_valid_o, trace_o, overflow_o, drop_cnt_o
    );

endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding trace records.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
    parameter int DEPTH = retire_trace_pkg::DEPTH_DEFAULT,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == FULL_CNT);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    // Empty reads as zero so the head never exposes a stale entry.
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Turns the retirement stream into trace records: each record is completed by its successor's PC
// (or by a drain), numbered, and queued; records arriving at a full queue are counted as drops.
module retire_trace_buffer
    import retire_trace_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    retire_trace_buffer_if.slave  bus
);

    logic             r_pend_vld;
    logic [XLEN-1:0]  r_pend_pc;
    logic [31:0]      r_pend_insn;
    logic [4:0]       r_pend_rd;
    logic [XLEN-1:0]  r_pend_val;
    logic [63:0]      r_order;
    logic             r_overflow;
    logic [15:0]      r_drop_cnt;

    logic             w_keep_rd;
    logic             w_push_succ;
    logic             w_push_drain;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic             w_valid;
    trace_rec_t       w_rec;
    trace_rec_t       w_head;

    // x0 writes and non-writing instructions both report rd as 0/0.
    assign w_keep_rd    = bus.wb_we_i & (bus.wb_dst_i != 5'd0);
    assign w_push_succ  = bus.wb_valid_i & r_pend_vld;
    assign w_push_drain = bus.drain_i & ~bus.wb_valid_i & r_pend_vld;
    assign w_push       = w_push_succ | w_push_drain;

    assign w_valid = ~w_empty & ~rst;
    assign w_pop   = w_valid & bus.trace_ready_i;
    assign w_drop  = w_push & w_full & ~w_pop;

    always_comb begin
        w_rec          = '0;
        w_rec.order    = r_order;
        w_rec.pc_rdata = r_pend_pc;
        w_rec.pc_wdata = bus.wb_valid_i ? bus.wb_pc_i : r_pend_pc + XLEN'(4);
        w_rec.insn     = r_pend_insn;
        w_rec.rd_addr  = r_pend_rd;
        w_rec.rd_wdata = r_pend_val;
        w_rec.drained  = ~bus.wb_valid_i;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push & ~w_drop & ~rst),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_order    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (bus.wb_valid_i)   r_pend_vld <= 1'b1;
            else if (w_push_drain) r_pend_vld <= 1'b0;
            // Dropped records still consume an order number so gaps are visible downstream.
            if (w_push) r_order <= r_order + 64'd1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wb_valid_i) begin
            r_pend_pc   <= bus.wb_pc_i;
            r_pend_insn <= bus.wb_insn_i;
            r_pend_rd   <= w_keep_rd ? bus.wb_dst_i : 5'd0;
            r_pend_val  <= w_keep_rd ? bus.wb_r_i : '0;
        end
    end

    assign bus.trace_valid_o = w_valid;
    assign bus.trace_o       = rst ? '0 : w_head;
    assign bus.overflow_o    = r_overflow & ~rst;
    assign bus.drop_cnt_o    = rst ? 16'd0 : r_drop_cnt;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (XLEN=32, DEPTH=4) with hand-computed expectations.
module tb_retire_trace_buffer;
    import retire_trace_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    retire_trace_buffer_if #(.XLEN(32)) bus ();

    retire_trace_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic we,
                          input logic [4:0] dst, input logic [31:0] val);
        bus.wb_valid_i = 1'b1;
        bus.wb_pc_i    = pc;
        bus.wb_insn_i  = insn;
        bus.wb_we_i    = we;
        bus.wb_dst_i   = dst;
        bus.wb_r_i     = val;
        step();
        bus.wb_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        bus.trace_ready_i = 1'b1;
        step();
        bus.trace_ready_i = 1'b0;
    endtask

    task automatic drain_one();
        bus.drain_i = 1'b1;
        step();
        bus.drain_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_valid_i    = 1'b0;
        bus.wb_pc_i       = '0;
        bus.wb_insn_i     = '0;
        bus.wb_we_i       = 1'b0;
        bus.wb_dst_i      = '0;
        bus.wb_r_i        = '0;
        bus.drain_i       = 1'b0;
        bus.trace_ready_i = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid", 64'(bus.trace_valid_o), 64'd0);
        chk("rst_ovf",   64'(bus.overflow_o), 64'd0);
        chk("rst_drop",  64'(bus.drop_cnt_o), 64'd0);
        chk("rst_trace", 64'(bus.trace_o.order | 64'(bus.trace_o.pc_rdata)), 64'd0);
        rst = 1'b0;

        // First retirement alone: nothing pushed
        retire(32'h200, 32'h00100093, 1'b1, 5'd1, 32'h1);
        chk("first_no_push", 64'(bus.trace_valid_o), 64'd0);
        // Successor completes record 0, visible right after the push edge
        retire(32'h204, 32'h00500013, 1'b1, 5'd0, 32'h5);
        chk("r0_valid",  64'(bus.trace_valid_o), 64'd1);
        chk("r0_order",  bus.trace_o.order, 64'd0);
        chk("r0_pcr",    64'(bus.trace_o.pc_rdata), 64'h200);
        chk("r0_pcw",    64'(bus.trace_o.pc_wdata), 64'h204);
        chk("r0_insn",   64'(bus.trace_o.insn), 64'h00100093);
        chk("r0_rd",     64'(bus.trace_o.rd_addr), 64'd1);
        chk("r0_rdw",    64'(bus.trace_o.rd_wdata), 64'd1);
        chk("r0_drn",    64'(bus.trace_o.drained), 64'd0);

        // x0 destination record, and we=0 pending afterwards
        retire(32'h208, 32'h00700113, 1'b0, 5'd2, 32'h7);
        pop_one();
        chk("r1_order",  bus.trace_o.order, 64'd1);
        chk("r1_pcr",    64'(bus.trace_o.pc_rdata), 64'h204);
        chk("r1_pcw",    64'(bus.trace_o.pc_wdata), 64'h208);
        chk("r1_rd",     64'(bus.trace_o.rd_addr), 64'd0);
        chk("r1_rdw",    64'(bus.trace_o.rd_wdata), 64'd0);
        pop_one();
        chk("empty_after_pops", 64'(bus.trace_valid_o), 64'd0);

        // Drain of a we=0 record
        drain_one();
        chk("d0_order",  bus.trace_o.order, 64'd2);
        chk("d0_pcw",    64'(bus.trace_o.pc_wdata), 64'h20C);
        chk("d0_drn",    64'(bus.trace_o.drained), 64'd1);
        chk("d0_rd",     64'(bus.trace_o.rd_addr), 64'd0);
        chk("d0_rdw",    64'(bus.trace_o.rd_wdata), 64'd0);
        pop_one();
        drain_one();
        chk("drain_idle", 64'(bus.trace_valid_o), 64'd0);

        // Pending at 0x300, then drain
        retire(32'h300, 32'h00000013, 1'b1, 5'd3, 32'h33);
        chk("p300_no_push", 64'(bus.trace_valid_o), 64'd0);
        drain_one();
        chk("d1_order",  bus.trace_o.order, 64'd3);
        chk("d1_pcr",    64'(bus.trace_o.pc_rdata), 64'h300);
        chk("d1_pcw",    64'(bus.trace_o.pc_wdata), 64'h304);
        chk("d1_drn",    64'(bus.trace_o.drained), 64'd1);
        chk("d1_rdw",    64'(bus.trace_o.rd_wdata), 64'h33);
        pop_one();
        drain_one();
        chk("d1_nothing_pending", 64'(bus.trace_valid_o), 64'd0);

        // Overflow: ready low, DEPTH+2 retirements -> 4 stored, 1 dropped
        for (int i = 0; i < 6; i++) begin
            retire(32'h400 + 32'(4 * i), 32'h13, 1'b1, 5'd4, 32'(i));
            if (i == 1) chk("ovf_first_head", bus.trace_o.order, 64'd4);
        end
        chk("ovf_flag",   64'(bus.overflow_o), 64'd1);
        chk("ovf_cnt",    64'(bus.drop_cnt_o), 64'd1);
        chk("ovf_head",   bus.trace_o.order, 64'd4);
        chk("ovf_headpc", 64'(bus.trace_o.pc_rdata), 64'h400);
        step();
        chk("ovf_stable", bus.trace_o.order, 64'd4);

        // Full FIFO: push (drain of 0x414) and pop on the same cycle -> no drop
        bus.drain_i       = 1'b1;
        bus.trace_ready_i = 1'b1;
        step();
        bus.drain_i       = 1'b0;
        bus.trace_ready_i = 1'b0;
        chk("full_pp_cnt",  64'(bus.drop_cnt_o), 64'd1);
        chk("full_pp_head", bus.trace_o.order, 64'd5);
        pop_one();
        chk("pop_o6", bus.trace_o.order, 64'd6);
        pop_one();
        chk("pop_o7", bus.trace_o.order, 64'd7);
        pop_one();
        chk("pop_gap_o9", bus.trace_o.order, 64'd9);
        chk("pop_o9_pcw", 64'(bus.trace_o.pc_wdata), 64'h418);
        pop_one();
        chk("full_pp_occ", 64'(bus.trace_valid_o), 64'd0);

        // Reset with 3 stored and one pending
        for (int i = 0; i < 4; i++) retire(32'h500 + 32'(4 * i), 32'h13, 1'b1, 5'd5, 32'h55);
        chk("pre_rst_head", bus.trace_o.order, 64'd10);
        rst = 1'b1;
        step();
        chk("rst2_valid", 64'(bus.trace_valid_o), 64'd0);
        chk("rst2_drop",  64'(bus.drop_cnt_o), 64'd0);
        chk("rst2_ovf",   64'(bus.overflow_o), 64'd0);
        rst = 1'b0;
        retire(32'h600, 32'h13, 1'b1, 5'd6, 32'h66);
        chk("post_rst_no_push", 64'(bus.trace_valid_o), 64'd0);
        retire(32'h604, 32'h13, 1'b1, 5'd6, 32'h67);
        chk("post_rst_order", bus.trace_o.order, 64'd0);
        chk("post_rst_pcr",   64'(bus.trace_o.pc_rdata), 64'h600);
        chk("post_rst_rdw",   64'(bus.trace_o.rd_wdata), 64'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32: width of PC, instruction and register data.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port wb_valid_i  input  1: a non-bubble instruction retires this cycle.
REQ-006 Port wb_pc_i  input  XLEN: PC of the retiring instruction.
REQ-007 Port wb_insn_i  input  32: encoding of the retiring instruction.
REQ-008 Port wb_we_i  input  1: retiring instruction writes rd.
REQ-009 Port wb_dst_i  input  5: rd index.
REQ-010 Port wb_r_i  input  XLEN: rd write value.
REQ-011 Port drain_i  input  1: close out the pending record without waiting for a successor.
REQ-012 Port trace_valid_o  output  1: head record available.
REQ-013 Port trace_ready_i  input  1: consumer accepts the head record.
REQ-014 Port trace_o  output  record: order[63:0], pc_rdata, pc_wdata, insn, rd_addr, rd_wdata, drained.
REQ-015 Port overflow_o  output  1: sticky flag; at least one record has been dropped.
REQ-016 Port drop_cnt_o  output  16: count of dropped records, saturating.

Function
REQ-017 A retirement is captured into a single pending register holding pc, insn, rd and value. rd_addr and rd_wdata are forced to 0 when wb_we_i=0 or wb_dst_i=0.
REQ-018 When wb_valid_i=1 and a record is pending, push the pending record with pc_wdata=wb_pc_i and drained=0, then load the new retirement into the pending register in the same cycle.
REQ-019 When wb_valid_i=1 and nothing is pending, only load the pending register; no push occurs.
REQ-020 When drain_i=1, wb_valid_i=0 and a record is pending, push it with pc_wdata=pc_rdata+4, drained=1, and clear pending.
REQ-021 When drain_i=1 and wb_valid_i=1 on the same cycle, REQ-018 takes priority and the new retirement stays pending.
REQ-022 The order field starts at 0 and increments by 1 per pushed record. Dropped records also consume an order value, so gaps in order reveal the drops.
REQ-023 The FIFO is first-word-fall-through. trace_valid_o=1 iff the FIFO is non-empty, and trace_o always presents the head entry.
REQ-024 A pop occurs iff trace_valid_o and trace_ready_i are both 1.
REQ-025 Push and pop on the same cycle are both honoured in any state, including full; occupancy is then unchanged.
REQ-026 A push while full without a simultaneous pop drops the record, sets overflow_o, and increments drop_cnt_o, which saturates at 16'hFFFF.
REQ-027 Read and write pointers wrap modulo DEPTH. Occupancy is tracked with a count of width log2(DEPTH)+1.
REQ-028 Latency: a record is visible on trace_o the cycle after its push when the FIFO was empty.
REQ-029 The head record is held stable while trace_valid_o=1 and trace_ready_i=0.

Reset
REQ-030 While rst=1:
- pending is cleared and the FIFO is emptied
- order is reset to 0
- trace_valid_o=0, overflow_o=0, drop_cnt_o=0
- trace_o=0
- any in-flight push is discarded
REQ-031 The first retirement after rst deasserts is treated as having nothing pending.

Structure
REQ-032 The trace record struct, XLEN default and DEPTH default live in shared package retire_trace_pkg.
REQ-033 Storage is one sub-module, trace_fifo: a parameterised FWFT FIFO with push, pop, full, empty and data ports. Pending, order and overflow logic stay in the parent.

Verification
REQ-034 Retire PC 0x200 then 0x204, ready=1 -> one record with order=0, pc_rdata=0x200, pc_wdata=0x204, trace_valid_o high one cycle later.
REQ-035 Retire addi x0 (we=1, dst=0) followed by a successor -> record rd_addr=0, rd_wdata=0.
REQ-036 Hold ready=0 and retire DEPTH+2 instructions -> DEPTH records stored, overflow_o=1, drop_cnt_o=1, head record stable; after release, order values show a gap of 1.
REQ-037 Pending at PC 0x300, assert drain_i with wb_valid_i=0 -> record pc_wdata=0x304, drained=1, and nothing pending afterwards.
REQ-038 FIFO full, ready=1 and a push on the same cycle -> no drop, occupancy stays at DEPTH, records pop in order.
REQ-039 Assert rst with 3 entries stored and a record pending -> next cycle trace_valid_o=0, drop_cnt_o=0, and the next record pushed has order=0.
